// File: rtl/qram_access_scheduler_if.sv
// Requester and QRAM-cell signal bundle for qram_access_scheduler.
// slave: the scheduler side; master: requesters plus the QRAM cell model.
interface qram_access_scheduler_if;
    logic ReqA;
    logic ReqB;
    logic WriteA;
    logic WriteB;
    logic AddrA;
    logic AddrB;
    logic DataA;
    logic DataB;
    logic GrantA;
    logic GrantB;
    logic DoneA;
    logic DoneB;
    logic RdData;
    logic Err;
    logic AddressQBit;
    logic inputQBit;
    logic Read;
    logic Write;
    logic outputQBit;

    modport slave (
        input  ReqA, ReqB, WriteA, WriteB, AddrA, AddrB, DataA, DataB,
        input  outputQBit,
        output GrantA, GrantB, DoneA, DoneB, RdData, Err,
        output AddressQBit, inputQBit, Read, Write
    );

    modport master (
        output ReqA, ReqB, WriteA, WriteB, AddrA, AddrB, DataA, DataB,
        output outputQBit,
        input  GrantA, GrantB, DoneA, DoneB, RdData, Err,
        input  AddressQBit, inputQBit, Read, Write
    );
endinterface

// File: rtl/qram_access_scheduler.sv
// Two-requester round-robin scheduler for a single QRAM cell pair.
// Optional write-verify read-back enabled by defining QRAM_SCHED_WRITE_VERIFY_EN.
module qram_access_scheduler #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                    DDRClockP,
    input logic                    Reset,
    qram_access_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        WAIT,
        VERIFY,
        DONE
    } stateT;

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] READ_LOAD  = 4'(READ_LATENCY - 1);

    stateT      state;
    stateT      stateNext;
    logic       ownerB;
    logic       ownerBNext;
    logic       favourB;
    logic       favourBNext;
    logic       opWrite;
    logic       opWriteNext;
    logic       opAddr;
    logic       opAddrNext;
    logic       opData;
    logic       opDataNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;
    logic       rdData;
    logic       rdDataNext;
    logic       pickB;

    logic       busy;
    logic       doneOut;
    logic       addrOut;
    logic       dataOut;
    logic       readOut;
    logic       writeOut;

`ifdef QRAM_SCHED_WRITE_VERIFY_EN
    logic       err;
    logic       errNext;
`endif

    always_ff @(posedge DDRClockP) begin
        if (Reset) begin
            state   <= IDLE;
            ownerB  <= 1'b0;
            favourB <= 1'b0;
            opWrite <= 1'b0;
            opAddr  <= 1'b0;
            opData  <= 1'b0;
            cnt     <= '0;
            rdData  <= 1'b0;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
            err     <= 1'b0;
`endif
        end else begin
            state   <= stateNext;
            ownerB  <= ownerBNext;
            favourB <= favourBNext;
            opWrite <= opWriteNext;
            opAddr  <= opAddrNext;
            opData  <= opDataNext;
            cnt     <= cntNext;
            rdData  <= rdDataNext;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
            err     <= errNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        ownerBNext  = ownerB;
        favourBNext = favourB;
        opWriteNext = opWrite;
        opAddrNext  = opAddr;
        opDataNext  = opData;
        cntNext     = cnt;
        rdDataNext  = rdData;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
        errNext     = err;
`endif
        pickB       = 1'b0;
        busy        = 1'b0;
        doneOut     = 1'b0;
        addrOut     = 1'b0;
        dataOut     = 1'b0;
        readOut     = 1'b0;
        writeOut    = 1'b0;

        case (state)
            IDLE: begin
                // B wins only when A is absent or when A was the last one served
                pickB = bus.ReqB && (!bus.ReqA || favourB);
                if (bus.ReqA || bus.ReqB) begin
                    ownerBNext  = pickB;
                    favourBNext = !pickB;
                    opWriteNext = pickB ? bus.WriteB : bus.WriteA;
                    opAddrNext  = pickB ? bus.AddrB  : bus.AddrA;
                    opDataNext  = pickB ? bus.DataB  : bus.DataA;
                    cntNext     = SETUP_LOAD;
                    rdDataNext  = 1'b0;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
                    errNext     = 1'b0;
`endif
                    stateNext   = ADDR;
                end
            end

            ADDR: begin
                busy    = 1'b1;
                addrOut = opAddr;
                if (cnt == 4'd0) begin
                    stateNext = STROBE;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end

            STROBE: begin
                busy    = 1'b1;
                addrOut = opAddr;
                if (opWrite) begin
                    writeOut = 1'b1;
                    dataOut  = opData;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
                    stateNext = VERIFY;
`else
                    stateNext = DONE;
`endif
                end else begin
                    readOut   = 1'b1;
                    cntNext   = READ_LOAD;
                    stateNext = WAIT;
                end
            end

            VERIFY: begin
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
                busy      = 1'b1;
                addrOut   = opAddr;
                readOut   = 1'b1;
                cntNext   = READ_LOAD;
                stateNext = WAIT;
`else
                stateNext = IDLE;
`endif
            end

            WAIT: begin
                busy    = 1'b1;
                addrOut = opAddr;
                if (cnt == 4'd0) begin
                    // WAIT is shared by plain reads and write read-back
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
                    if (opWrite) begin
                        errNext = bus.outputQBit != opData;
                    end else begin
                        rdDataNext = bus.outputQBit;
                    end
`else
                    rdDataNext = bus.outputQBit;
`endif
                    stateNext = DONE;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end

            DONE: begin
                doneOut   = 1'b1;
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.GrantA      = busy && !ownerB;
    assign bus.GrantB      = busy && ownerB;
    assign bus.DoneA       = doneOut && !ownerB;
    assign bus.DoneB       = doneOut && ownerB;
    assign bus.RdData      = doneOut && rdData;
    assign bus.AddressQBit = addrOut;
    assign bus.inputQBit   = dataOut;
    assign bus.Read        = readOut;
    assign bus.Write       = writeOut;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
    assign bus.Err         = doneOut && err;
`else
    assign bus.Err         = 1'b0;
`endif

endmodule

// File: tb/tb_qram_access_scheduler.sv
// Directed bench for qram_access_scheduler with a queue scoreboard of expected Done events.
// Also exercises the write-verify path when QRAM_SCHED_WRITE_VERIFY_EN is defined.
module tb_qram_access_scheduler;

    localparam int SU = 1;
    localparam int RL = 2;
`ifdef QRAM_SCHED_WRITE_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    typedef struct {
        logic isB;
        logic rd;
        logic err;
        int   cyc;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qram_access_scheduler_if bus ();

    qram_access_scheduler #(
        .SETUP_CYCLES(SU),
        .READ_LATENCY(RL)
    ) dut (
        .DDRClockP(clk),
        .Reset    (rst),
        .bus      (bus)
    );

    // QRAM cell model: read data becomes correct RL cycles after the Read strobe
    logic mem [2] = '{1'b0, 1'b0};
    logic pend = 1'b0;
    int   delay = 0;
    logic invertMode = 1'b0;

    always @(posedge clk) begin
        if (bus.Write) mem[bus.AddressQBit] <= bus.inputQBit;
        if (bus.Read) begin
            pend  <= mem[bus.AddressQBit] ^ invertMode;
            delay <= RL - 1;
        end else if (delay > 0) begin
            delay <= delay - 1;
        end
    end
    assign bus.outputQBit = (delay == 0) ? pend : ~pend;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  readPulses = 0;
    int  writePulses = 0;
    expT sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check(tag, 32'({bus.GrantA, bus.GrantB, bus.DoneA, bus.DoneB, bus.RdData, bus.Err,
                        bus.AddressQBit, bus.inputQBit, bus.Read, bus.Write}), 32'd0);
    endtask

    task automatic tick();
        expT e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        readPulses  += int'(bus.Read);
        writePulses += int'(bus.Write);
        check("grant_onehot", 32'(bus.GrantA & bus.GrantB), 32'd0);
        check("rw_exclusive", 32'(bus.Read & bus.Write), 32'd0);
        if (bus.DoneA === 1'b1 || bus.DoneB === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'({bus.DoneA, bus.DoneB}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_a", 32'(bus.DoneA), 32'(!e.isB));
                check("done_b", 32'(bus.DoneB), 32'(e.isB));
                check("rd_data", 32'(bus.RdData), 32'(e.rd));
                check("err", 32'(bus.Err), 32'(e.err));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("grant_at_done", 32'({bus.GrantA, bus.GrantB}), 32'd0);
            end
        end
    endtask

    task automatic pushExp(input logic isB, input logic rd, input logic err, input int lat);
        expT e;
        e.isB = isB;
        e.rd  = rd;
        e.err = err;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // One request; Req drops and the request fields are scrambled right after the grant
    task automatic runOp(input logic isB, input logic wr, input logic addr, input logic data,
                         input logic rd, input logic err);
        int r0 = readPulses;
        int w0 = writePulses;
        int lat;
        lat = wr ? (VERIFY_EN ? SU + RL + 3 : SU + 2) : SU + RL + 2;
        if (isB) begin
            bus.ReqB = 1'b1; bus.WriteB = wr; bus.AddrB = addr; bus.DataB = data;
        end else begin
            bus.ReqA = 1'b1; bus.WriteA = wr; bus.AddrA = addr; bus.DataA = data;
        end
        pushExp(isB, rd, err, lat);
        tick();
        check("grant", 32'({bus.GrantB, bus.GrantA}), isB ? 32'd2 : 32'd1);
        check("addr_setup", 32'(bus.AddressQBit), 32'(addr));
        check("setup_no_strobe", 32'({bus.Read, bus.Write}), 32'd0);
        if (isB) begin
            bus.ReqB = 1'b0; bus.WriteB = !wr; bus.AddrB = !addr; bus.DataB = !data;
        end else begin
            bus.ReqA = 1'b0; bus.WriteA = !wr; bus.AddrA = !addr; bus.DataA = !data;
        end
        for (int i = 0; i < SU; i++) tick();
        check("strobe_write", 32'(bus.Write), 32'(wr));
        check("strobe_read", 32'(bus.Read), 32'(!wr));
        check("strobe_data", 32'(bus.inputQBit), 32'(wr & data));
        check("strobe_addr", 32'(bus.AddressQBit), 32'(addr));
        waitIdle(40);
        check("write_pulses", 32'(writePulses - w0), 32'(wr));
        check("read_pulses", 32'(readPulses - r0), (wr && !VERIFY_EN) ? 32'd0 : 32'd1);
        tick();
    endtask

    initial begin
        int w0;
        bus.ReqA = 1'b0; bus.ReqB = 1'b0; bus.WriteA = 1'b0; bus.WriteB = 1'b0;
        bus.AddrA = 1'b0; bus.AddrB = 1'b0; bus.DataA = 1'b0; bus.DataB = 1'b0;
        tick();
        tick();
        checkAllZero("reset_outputs");
        rst = 1'b0;
        tick();
        checkAllZero("idle_outputs");

        runOp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        runOp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        runOp(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        runOp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        runOp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Both held from reset: A first, then strict alternation
        rst = 1'b1;
        tick();
        tick();
        checkAllZero("reset_again");
        bus.ReqA = 1'b1; bus.WriteA = 1'b1; bus.AddrA = 1'b0; bus.DataA = 1'b1;
        bus.ReqB = 1'b1; bus.WriteB = 1'b1; bus.AddrB = 1'b1; bus.DataB = 1'b0;
        rst = 1'b0;
        w0 = writePulses;
        if (VERIFY_EN) begin
            pushExp(1'b0, 1'b0, 1'b0, SU + RL + 3);
            pushExp(1'b1, 1'b0, 1'b0, 2 * (SU + RL + 4) - 1);
            pushExp(1'b0, 1'b0, 1'b0, 3 * (SU + RL + 4) - 1);
            pushExp(1'b1, 1'b0, 1'b0, 4 * (SU + RL + 4) - 1);
        end else begin
            pushExp(1'b0, 1'b0, 1'b0, SU + 2);
            pushExp(1'b1, 1'b0, 1'b0, 2 * (SU + 3) - 1);
            pushExp(1'b0, 1'b0, 1'b0, 3 * (SU + 3) - 1);
            pushExp(1'b1, 1'b0, 1'b0, 4 * (SU + 3) - 1);
        end
        waitIdle(80);
        bus.ReqA = 1'b0;
        bus.ReqB = 1'b0;
        check("rr_write_pulses", 32'(writePulses - w0), 32'd4);
        tick();

        // Reset during WAIT aborts the read
        bus.ReqA = 1'b1; bus.WriteA = 1'b0; bus.AddrA = 1'b0;
        tick();
        bus.ReqA = 1'b0;
        for (int i = 0; i < SU + 1; i++) tick();
        check("in_wait_grant", 32'({bus.GrantB, bus.GrantA}), 32'd1);
        check("in_wait_no_strobe", 32'({bus.Read, bus.Write}), 32'd0);
        rst = 1'b1;
        tick();
        checkAllZero("abort_outputs");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkAllZero("after_abort");

        runOp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        if (VERIFY_EN) begin
            invertMode = 1'b1;
            runOp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            invertMode = 1'b0;
            runOp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end else begin
            invertMode = 1'b1;
            runOp(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            invertMode = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
